// File: rtl/cache_mem_responder_pkg.sv
// cache_mem_pkg: shared widths and encodings for the cache line memory responder
package cache_mem_pkg;
  localparam int LINE_W = 128;
  localparam int MEM_ADDR_W = 28;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;
  typedef enum logic {
    KIND_READ  = 1'b0,
    KIND_WRITE = 1'b1
  } kind_t;
endpackage

// File: rtl/cache_mem_responder_if.sv
// cache_mem_if: cache-to-memory line transfer bus
interface cache_mem_if;
  import cache_mem_pkg::*;
  logic                  mem_read;
  logic                  mem_write;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0]     mem_wdata;
  logic [LINE_W-1:0]     mem_rdata;
  logic                  mem_ready;
  modport master (output mem_read, mem_write, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave (input mem_read, mem_write, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/cache_mem_responder_mem_line_ram.sv
// mem_line_ram: unreset line storage with one synchronous write port and one registered read port
module mem_line_ram
  import cache_mem_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [LINE_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  ridx,
  output logic [LINE_W-1:0] rdata
);
  logic [LINE_W-1:0] mem [2**IDX_W];
  // write commits at the edge; read data is captured only when requested so it holds between reads
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
    if (re) rdata <= mem[ridx];
  end
endmodule

// File: rtl/cache_mem_responder.sv
// cache_mem_responder: slow-memory model answering one cache line transfer per request after LATENCY cycles
module cache_mem_responder
  import cache_mem_pkg::*;
#(
  parameter int LATENCY = 8,
  parameter int IDX_W   = 8
) (
  input logic        clk,
  input logic        proc_reset_n,
  cache_mem_if.slave bus
);
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);
  state_t            state_q, state_d;
  kind_t             kind_q, kind_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d, rd_idx;
  logic [LINE_W-1:0] wdata_q, wdata_d, ram_rdata;
  logic              ready_q, ready_d, rvalid_q, rvalid_d;
  logic              rd_en, req_live, unused_addr;
  assign unused_addr   = ^bus.mem_addr[MEM_ADDR_W-1:IDX_W];
  assign req_live      = (kind_q == KIND_WRITE) ? bus.mem_write : bus.mem_read;
  // with LATENCY=1 the read is issued in the accept cycle, before idx_q is loaded
  assign rd_idx        = (state_q == IDLE) ? bus.mem_addr[IDX_W-1:0] : idx_q;
  assign bus.mem_ready = ready_q;
  // rdata is zero after reset until the first read response refreshes the RAM output register
  assign bus.mem_rdata = rvalid_q ? ram_rdata : '0;
  // next-state logic: accept in IDLE, count down or abort in WAIT, single-cycle RESP
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    ready_d = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: if (bus.mem_write || bus.mem_read) begin
        kind_d  = bus.mem_write ? KIND_WRITE : KIND_READ;
        idx_d   = bus.mem_addr[IDX_W-1:0];
        wdata_d = bus.mem_wdata;
        cnt_d   = CNT_INIT;
        if (LATENCY > 1) state_d = WAIT;
        else state_d = RESP;
        ready_d = (LATENCY == 1);
        rd_en   = (LATENCY == 1) && !bus.mem_write;
      end
      WAIT: if (!req_live) state_d = IDLE;
        else if (cnt_q == 8'd1) begin
          state_d = RESP;
          ready_d = 1'b1;
          rd_en   = (kind_q == KIND_READ);
        end else cnt_d = cnt_q - 8'd1;
      default: state_d = IDLE;
    endcase
    rvalid_d = rvalid_q | rd_en;
  end
  // state and registered outputs; the storage array is deliberately outside the reset domain
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q  <= IDLE;
      kind_q   <= KIND_READ;
      cnt_q    <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
    end
  end
  mem_line_ram #(.IDX_W(IDX_W)) u_ram (
    .clk   (clk),
    .we    ((state_q == RESP) && (kind_q == KIND_WRITE)),
    .widx  (idx_q),
    .wdata (wdata_q),
    .re    (rd_en),
    .ridx  (rd_idx),
    .rdata (ram_rdata)
  );
endmodule

// File: tb/tb_cache_mem_responder.sv
// tb_cache_mem_responder: directed vector and corner-case checks for the line memory responder
module tb_cache_mem_responder;
  import cache_mem_pkg::*;
  typedef struct {
    logic         w;
    logic         r;
    logic [27:0]  a;
    logic [127:0] d;
    logic [127:0] exp;
  } vec_t;
  localparam logic [127:0] D10 = 128'h00004444_00003333_00002222_00001111;
  localparam logic [127:0] A5  = {16{8'hA5}};
  localparam logic [127:0] E9  = 128'hE9E9_0009_1234_5678_9ABC_DEF0_0BAD_F00D;
  localparam logic [127:0] D20 = 128'h2020_2020_0000_0001_2020_2020_0000_0002;
  localparam logic [127:0] DA  = 128'hDADA_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] DB  = 128'hDBDB_9999_8888_7777_6666_5555_4444_3333;
  localparam logic [127:0] DC  = 128'hC0C0_FFFF_0000_AAAA_5555_1234_4321_ABCD;
  logic clk = 1'b0;
  logic proc_reset_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  cache_mem_if bus8();
  cache_mem_if bus1();
  cache_mem_responder #(.LATENCY(8), .IDX_W(8)) dut8 (.clk(clk), .proc_reset_n(proc_reset_n), .bus(bus8));
  cache_mem_responder #(.LATENCY(1), .IDX_W(8)) dut1 (.clk(clk), .proc_reset_n(proc_reset_n), .bus(bus1));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic drive(input bit fast, input logic w, input logic r, input logic [27:0] a, input logic [127:0] d);
    if (fast) begin
      bus1.mem_write = w; bus1.mem_read = r; bus1.mem_addr = a; bus1.mem_wdata = d;
    end else begin
      bus8.mem_write = w; bus8.mem_read = r; bus8.mem_addr = a; bus8.mem_wdata = d;
    end
  endtask
  function automatic logic rdy(input bit fast);
    return fast ? bus1.mem_ready : bus8.mem_ready;
  endfunction
  function automatic logic [127:0] rdat(input bit fast);
    return fast ? bus1.mem_rdata : bus8.mem_rdata;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_rdy(input bit fast, output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (rdy(fast)) begin
        n = i;
        break;
      end
    end
  endtask
  task automatic xfer(input bit fast, input logic w, input logic r, input logic [27:0] a,
                      input logic [127:0] d, output int lat, output logic [127:0] rd);
    drive(fast, w, r, a, d);
    wait_rdy(fast, lat);
    rd = rdat(fast);
    drive(fast, 1'b0, 1'b0, a, d);
    if (lat >= 0) begin
      tick();
      chk("ready_single_pulse", 128'(rdy(fast)), 128'd0);
    end
  endtask
  initial begin
    vec_t tbl[9];
    logic [127:0] last_rd, rd, exp_rd;
    int lat, n;
    logic seen;
    tbl[0] = '{1'b1, 1'b0, 28'h0000010, D10, '0};
    tbl[1] = '{1'b0, 1'b1, 28'h0000010, '0, D10};
    tbl[2] = '{1'b1, 1'b1, 28'h0000003, A5, '0};
    tbl[3] = '{1'b0, 1'b1, 28'h0000003, '0, A5};
    tbl[4] = '{1'b1, 1'b0, 28'h0000007, 128'h1, '0};
    tbl[5] = '{1'b1, 1'b0, 28'h0000009, E9, '0};
    tbl[6] = '{1'b1, 1'b0, 28'h0000020, D20, '0};
    tbl[7] = '{1'b0, 1'b1, 28'h0001020, '0, D20};
    tbl[8] = '{1'b0, 1'b1, 28'h0000007, '0, 128'h1};
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (3) tick();
    chk("reset_ready8", 128'(bus8.mem_ready), 128'd0);
    chk("reset_rdata8", bus8.mem_rdata, 128'd0);
    chk("reset_ready1", 128'(bus1.mem_ready), 128'd0);
    chk("reset_rdata1", bus1.mem_rdata, 128'd0);
    proc_reset_n = 1'b1;
    tick();
    last_rd = '0;
    for (int i = 0; i < 9; i++) begin
      xfer(1'b0, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, lat, rd);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'd8);
      exp_rd = (tbl[i].r && !tbl[i].w) ? tbl[i].exp : last_rd;
      chk($sformatf("vec%0d_rdata", i), rd, exp_rd);
      last_rd = exp_rd;
    end
    drive(1'b0, 1'b1, 1'b0, 28'h5, DB);
    wait_rdy(1'b0, n);
    chk("wb_latency", 128'(n), 128'd8);
    drive(1'b0, 1'b0, 1'b1, 28'h9, '0);
    wait_rdy(1'b0, n);
    chk("refill_spacing", 128'(n), 128'd9);
    chk("refill_rdata", bus8.mem_rdata, E9);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 28'h10, '0);
    repeat (4) tick();
    drive(1'b0, 1'b0, 1'b0, 28'h10, '0);
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (bus8.mem_ready) seen = 1'b1;
    end
    chk("abort_no_ready", 128'(seen), 128'd0);
    xfer(1'b0, 1'b0, 1'b1, 28'h10, '0, lat, rd);
    chk("after_abort_latency", 128'(lat), 128'd8);
    chk("after_abort_rdata", rd, D10);
    drive(1'b0, 1'b1, 1'b0, 28'h30, DA);
    repeat (2) tick();
    drive(1'b0, 1'b1, 1'b0, 28'h31, DB);
    wait_rdy(1'b0, n);
    chk("latched_wr_latency", 128'(n + 2), 128'd8);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    xfer(1'b0, 1'b0, 1'b1, 28'h30, '0, lat, rd);
    chk("latched_wr_rdata", rd, DA);
    drive(1'b0, 1'b1, 1'b0, 28'h7, DC);
    repeat (5) tick();
    proc_reset_n = 1'b0;
    #1;
    chk("midreset_ready", 128'(bus8.mem_ready), 128'd0);
    chk("midreset_rdata", bus8.mem_rdata, 128'd0);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) tick();
    chk("midreset_still_no_ready", 128'(bus8.mem_ready), 128'd0);
    proc_reset_n = 1'b1;
    xfer(1'b0, 1'b0, 1'b1, 28'h7, '0, lat, rd);
    chk("post_reset_latency", 128'(lat), 128'd8);
    chk("post_reset_rdata", rd, 128'h1);
    xfer(1'b1, 1'b1, 1'b0, 28'h100, DC, lat, rd);
    chk("fast_wr_latency", 128'(lat), 128'd1);
    chk("fast_wr_rdata_hold", rd, 128'd0);
    xfer(1'b1, 1'b0, 1'b1, 28'h000, '0, lat, rd);
    chk("fast_rd_latency", 128'(lat), 128'd1);
    chk("fast_alias_rdata", rd, DC);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
